quantum_scheduler: RTL
======================

// Module: quantum_scheduler
// PURPOSE
//   OS-side counterpart of the PC's quantum preemption. It programs the quantum (qtm/flagQtm), dispatches user processes by driving
//   a jump target into the PC, and saves the interrupted PC on preemption so the process resumes later. Round-robin over NPROC slots.
//   Sits between the OS control path and the PC.
// PARAMETERS
//   NPROC     4    number of process slots (power of 2, >=2)
//   PC_W      32   PC / quantum width
//   SO_LIMIT  616  first address outside the OS image; user start/resume PCs must be >= this value
// PORTS
//   clk          in   1      system clock, rising edge
//   reset        in   1      synchronous, active-high
//   preempt      in   1      1-cycle pulse: quantum overflow, PC forced to 0
//   preempt_pc   in   PC_W   PC of the interrupted process, valid with preempt
//   proc_done    in   1      1-cycle pulse: the running process halted
//   so_dispatch  in   1      1-cycle pulse: OS requests the next process
//   so_qtm       in   PC_W   quantum to load on dispatch
//   reg_we       in   1      register a process start PC
//   reg_idx      in   log2(NPROC)  slot index for reg_we
//   reg_base     in   PC_W   start PC for reg_we
//   pcin         out  PC_W   jump target to PC
//   jump         out  1      1-cycle pulse: PC loads pcin
//   qtm          out  PC_W   quantum value to PC
//   flagQtm      out  1      1-cycle pulse: PC latches qtm
//   cur_proc     out  log2(NPROC)  slot currently or last dispatched
//   busy         out  1      high in every state except IDLE
//   no_ready     out  1      1-cycle pulse: dispatch requested, no valid slot
// BEHAVIOUR
//   Reset
//     All outputs 0. cur_proc = NPROC-1, so the first search starts at slot 0.
//     All slot valid bits 0; table contents don't-care. Reset mid-operation aborts to IDLE with no jump/flagQtm pulse.
//   Table
//     saved_pc[NPROC], valid[NPROC].
//     reg_we writes saved_pc[reg_idx] = reg_base and sets valid.
//     reg_we is ignored when reg_base < SO_LIMIT, or when reg_idx == cur_proc and state != IDLE.
//   FSM, all outputs registered:
//     IDLE
//       so_dispatch -> SELECT. preempt and proc_done are ignored.
//     SELECT
//       Round-robin search from cur_proc+1 mod NPROC, wrapping, over all NPROC slots (cur_proc is searched last).
//       Hit  -> cur_proc = hit, go LOAD.
//       Miss -> no_ready = 1 for one cycle, go IDLE.
//     LOAD
//       qtm = so_qtm (value captured at dispatch), flagQtm = 1 for this cycle -> LAUNCH.
//     LAUNCH
//       pcin = saved_pc[cur_proc], jump = 1 for this cycle -> RUN.
//     RUN
//       proc_done                         -> valid[cur_proc] = 0, go IDLE.
//       preempt                           -> saved_pc[cur_proc] = preempt_pc, go IDLE.
//       preempt with preempt_pc < SO_LIMIT -> clear valid instead (corrupt context).
//       proc_done and preempt in the same cycle: proc_done wins, nothing saved.
//       so_dispatch in RUN is ignored.
//   Latency
//     so_dispatch sampled at edge N -> flagQtm high in cycle N+2 -> jump high in cycle N+3 -> RUN from N+4.
//   qtm and pcin hold their last values after the pulses. Arithmetic is index wrap mod NPROC only; no PC arithmetic.
// STRUCTURE
//   sched_defs.vh: state localparams (IDLE, SELECT, LOAD, LAUNCH, RUN), SO_LIMIT default, IDX_W = log2(NPROC).
//   Sub-module proc_table: saved_pc/valid storage, one write port arbitrated save > reg_we, async read, valid vector out.
//   Round-robin search and FSM live in quantum_scheduler.
// TESTING
//   Register slots 0,1 with 700/900. Dispatch with so_qtm=20 ->
//     flagQtm at N+2 with qtm=20; jump at N+3 with pcin=700; cur_proc=0.
//   Preempt with preempt_pc=734 while RUN (slot 0). Dispatch ->
//     slot 1, pcin=900. Preempt at 950, dispatch -> slot 0, pcin=734.
//   proc_done on slot 1. Next two dispatches both select slot 0; valid[1]=0.
//   All slots invalid, so_dispatch -> no_ready pulse at N+1, no flagQtm/jump, back to IDLE.
//   preempt and proc_done in the same cycle in RUN -> slot cleared, saved_pc unchanged.
//   preempt_pc=100 -> slot cleared.
//   reg_base=500 -> write ignored.
//   reset asserted in LOAD -> next cycle all outputs 0, IDLE, valid all 0.

Source files
------------

// File: rtl/quantum_scheduler_pkg.sv
// rtl/quantum_scheduler_pkg.sv - shared state encodings and defaults for the quantum scheduler
package quantum_scheduler_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_LAUNCH = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;

    localparam int NPROC_DEFAULT    = 4;
    localparam int PC_W_DEFAULT     = 32;
    localparam int SO_LIMIT_DEFAULT = 616;

endpackage

// File: rtl/quantum_scheduler_proc_table.sv
// rtl/quantum_scheduler_proc_table.sv - per-slot saved PC and valid storage, single arbitrated write port
module quantum_scheduler_proc_table
    import quantum_scheduler_pkg::*;
#(
    parameter int NPROC = NPROC_DEFAULT,
    parameter int PC_W  = PC_W_DEFAULT,
    parameter int IDX_W = $clog2(NPROC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             save_en,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] run_idx,
    input  logic [PC_W-1:0]  save_pc,
    input  logic             reg_en,
    input  logic [IDX_W-1:0] reg_idx,
    input  logic [PC_W-1:0]  reg_pc,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [PC_W-1:0]  rd_pc,
    output logic [NPROC-1:0] valid
);

    logic [PC_W-1:0] saved_pc [NPROC];

    // Running-slot updates (save or clear) own the port; registration only gets it when they are idle.
    always_ff @(posedge clk) begin
        if (save_en) begin
            saved_pc[run_idx] <= save_pc;
        end else if (reg_en && !clr_en) begin
            saved_pc[reg_idx] <= reg_pc;
        end
    end

    // Valid bits follow the same arbitration; a clear never touches the stored PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else if (save_en) begin
            valid[run_idx] <= 1'b1;
        end else if (clr_en) begin
            valid[run_idx] <= 1'b0;
        end else if (reg_en) begin
            valid[reg_idx] <= 1'b1;
        end
    end

    assign rd_pc = saved_pc[rd_idx];

endmodule

// File: rtl/quantum_scheduler.sv
// rtl/quantum_scheduler.sv - round-robin process dispatcher that programs the PC quantum and jump target
module quantum_scheduler
    import quantum_scheduler_pkg::*;
#(
    parameter int NPROC    = NPROC_DEFAULT,
    parameter int PC_W     = PC_W_DEFAULT,
    parameter int SO_LIMIT = SO_LIMIT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     preempt,
    input  logic [PC_W-1:0]          preempt_pc,
    input  logic                     proc_done,
    input  logic                     so_dispatch,
    input  logic [PC_W-1:0]          so_qtm,
    input  logic                     reg_we,
    input  logic [$clog2(NPROC)-1:0] reg_idx,
    input  logic [PC_W-1:0]          reg_base,
    output logic [PC_W-1:0]          pcin,
    output logic                     jump,
    output logic [PC_W-1:0]          qtm,
    output logic                     flagQtm,
    output logic [$clog2(NPROC)-1:0] cur_proc,
    output logic                     busy,
    output logic                     no_ready
);

    localparam int IDX_W = $clog2(NPROC);
    localparam logic [PC_W-1:0] LIMIT = PC_W'(SO_LIMIT);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [PC_W-1:0]  qtm_cap;
    logic [NPROC-1:0] valid_vec;
    logic [PC_W-1:0]  rd_pc;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] cand;
    logic             save_en;
    logic             clr_en;
    logic             reg_ok;

    // Round-robin pick: walk offsets from far to near so the nearest valid slot after cur_proc wins;
    // offset NPROC wraps to cur_proc itself, making it the last choice.
    always_comb begin
        hit     = 1'b0;
        hit_idx = cur_proc;
        cand    = cur_proc;
        for (int i = NPROC; i >= 1; i--) begin
            cand = cur_proc + IDX_W'(i);
            if (valid_vec[cand]) begin
                hit     = 1'b1;
                hit_idx = cand;
            end
        end
    end

    // Next-state decode; preempt/proc_done only matter while a process runs.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (so_dispatch) state_nxt = S_SELECT;
            S_SELECT: state_nxt = hit ? S_LOAD : S_IDLE;
            S_LOAD:   state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN:    if (proc_done || preempt) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Context bookkeeping: proc_done beats preempt, and a preempt PC inside the OS image is treated as corrupt.
    always_comb begin
        save_en = (state == S_RUN) && preempt && !proc_done && (preempt_pc >= LIMIT);
        clr_en  = (state == S_RUN) && (proc_done || (preempt && (preempt_pc < LIMIT)));
        reg_ok  = reg_we && (reg_base >= LIMIT) && !((reg_idx == cur_proc) && (state != S_IDLE));
    end

    quantum_scheduler_proc_table #(
        .NPROC (NPROC),
        .PC_W  (PC_W),
        .IDX_W (IDX_W)
    ) u_table (
        .clk     (clk),
        .reset   (reset),
        .save_en (save_en),
        .clr_en  (clr_en),
        .run_idx (cur_proc),
        .save_pc (preempt_pc),
        .reg_en  (reg_ok),
        .reg_idx (reg_idx),
        .reg_pc  (reg_base),
        .rd_idx  (cur_proc),
        .rd_pc   (rd_pc),
        .valid   (valid_vec)
    );

    // State and registered outputs; pulses come from the state being left, values hold after the pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cur_proc <= '1;
            qtm_cap  <= '0;
            qtm      <= '0;
            pcin     <= '0;
            flagQtm  <= 1'b0;
            jump     <= 1'b0;
            no_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != S_IDLE);
            flagQtm  <= (state == S_LOAD);
            jump     <= (state == S_LAUNCH);
            no_ready <= (state == S_SELECT) && !hit;
            if ((state == S_IDLE) && so_dispatch) qtm_cap  <= so_qtm;
            if ((state == S_SELECT) && hit)       cur_proc <= hit_idx;
            if (state == S_LOAD)                  qtm      <= qtm_cap;
            if (state == S_LAUNCH)                pcin     <= rd_pc;
        end
    end

endmodule
